// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with valid/ready handshake.
// An optional skid entry lets in_ready come from a flop. The stage also
// presents write-back data, a forwarding candidate and a saturating count
// of retired register writes.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_to_reg,
    input  logic              in_reg_we,
    input  logic [DATA_W-1:0] in_outMem,
    input  logic [DATA_W-1:0] in_outAlu,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_to_reg,
    output logic              out_reg_we,
    output logic [DATA_W-1:0] out_outMem,
    output logic [DATA_W-1:0] out_outAlu,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_wdata,
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef struct packed {
        logic              to_reg;
        logic              reg_we;
        logic [DATA_W-1:0] mem;
        logic [DATA_W-1:0] alu;
        logic [RD_W-1:0]   rd;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t           state;
    entry_t           head;
    entry_t           skid;
    entry_t           in_entry;
    logic             ready_q;
    logic             accept;
    logic             retire;
    logic [CNT_W-1:0] cnt;

    // Build the incoming entry; writes to x0 are dropped at capture.
    always_comb begin
        in_entry        = '0;
        in_entry.to_reg = in_to_reg;
        in_entry.reg_we = in_reg_we && (in_rd != '0);
        in_entry.mem    = in_outMem;
        in_entry.alu    = in_outAlu;
        in_entry.rd     = in_rd;
    end

    assign out_valid = (state != EMPTY);
    assign in_ready  = (SKID != 0) ? ready_q : (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    // Occupancy FSM with head/skid storage and registered in_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            head    <= '0;
            skid    <= '0;
            ready_q <= 1'b1;
        end else if (flush) begin
            state   <= EMPTY;
            head    <= '0;
            skid    <= '0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head  <= in_entry;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        head <= in_entry;
                    end else if (accept && (SKID != 0)) begin
                        skid    <= in_entry;
                        state   <= TWO;
                        ready_q <= 1'b0;
                    end else if (retire) begin
                        head  <= '0;
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    // Skid entry becomes the head on the retiring edge.
                    if (retire) begin
                        head    <= skid;
                        skid    <= '0;
                        state   <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    head    <= '0;
                    skid    <= '0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of retired register writes; a flush edge suppresses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!flush && retire && head.reg_we && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign out_to_reg = head.to_reg;
    assign out_reg_we = head.reg_we;
    assign out_outMem = head.mem;
    assign out_outAlu = head.alu;
    assign out_rd     = head.rd;
    assign out_wdata  = head.to_reg ? head.mem : head.alu;
    assign fwd_valid  = out_valid && head.reg_we;
    assign fwd_rd     = head.rd;
    assign fwd_data   = out_wdata;
    assign retire_cnt = cnt;

endmodule
